// File: rtl/tile_ram_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : tile_ram_writer_if
// Purpose  : Command handshake and tile RAM write port for tile_ram_writer.
// Revision : 1.0
// ============================================================================
interface tile_ram_writer_if #(
  parameter int ROW_BITS = 5,
  parameter int COL_BITS = 5,
  parameter int DATA_W   = 8
) ();
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [1:0]                   cmd_op;
  logic [ROW_BITS-1:0]          cmd_row;
  logic [COL_BITS-1:0]          cmd_col;
  logic [15:0]                  cmd_data;
  logic                         wr_allow;
  logic [ROW_BITS+COL_BITS-1:0] ram_addr;
  logic [DATA_W-1:0]            ram_din;
  logic                         ram_we;
  logic                         busy;
  logic                         done;

  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_col, cmd_data, wr_allow,
    input  cmd_ready, ram_addr, ram_din, ram_we, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_col, cmd_data, wr_allow,
    output cmd_ready, ram_addr, ram_din, ram_we, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/tile_ram_writer.sv
`default_nettype none
// ============================================================================
// Module   : tile_ram_writer
// Purpose  : Expands PUT/HEX4/FILL commands into gated single-byte tile RAM writes.
// Revision : 1.0
// ============================================================================
module tile_ram_writer #(
  parameter int ROW_BITS = 5,
  parameter int COL_BITS = 5,
  parameter int DATA_W   = 8
) (
  input  wire logic       clk,
  input  wire logic       reset,
  tile_ram_writer_if.slave bus
);

  localparam int ADDR_W = ROW_BITS + COL_BITS;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_PUT  = 2'd1;
  localparam logic [1:0] OP_HEX4 = 2'd2;
  localparam logic [1:0] OP_FILL = 2'd3;

  localparam logic [COL_BITS-1:0] c_col_one  = COL_BITS'(1);
  localparam logic [ADDR_W-1:0]   c_addr_one = ADDR_W'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [15:0]         hex_q, hex_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                fire;
  logic                last;

  function automatic logic [DATA_W-1:0] nib_ext(input logic [3:0] nib);
    logic [DATA_W-1:0] v;
    v      = '0;
    v[3:0] = nib;
    return v;
  endfunction

  // Combinational so the write lands in the slot wr_allow grants this cycle
  assign fire          = (state_q == WRITE) && bus.wr_allow;
  assign bus.ram_we    = fire && !reset;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_din   = din_q;
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q == WRITE);
  assign bus.done      = done_q;

  always_comb begin
    last = 1'b1;
    case (op_q)
      OP_HEX4: last = (cnt_q == 2'd3);
      OP_FILL: last = &addr_q;
      default: last = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    din_d   = din_q;
    hex_d   = hex_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d  = bus.cmd_op;
          cnt_d = 2'd0;
          case (bus.cmd_op)
            OP_NOP: done_d = 1'b1;
            OP_PUT: begin
              addr_d  = {bus.cmd_row, bus.cmd_col};
              din_d   = bus.cmd_data[DATA_W-1:0];
              state_d = WRITE;
            end
            OP_HEX4: begin
              // hex_q keeps the not-yet-written nibbles left-aligned
              addr_d  = {bus.cmd_row, bus.cmd_col};
              din_d   = nib_ext(bus.cmd_data[15:12]);
              hex_d   = {bus.cmd_data[11:0], 4'h0};
              state_d = WRITE;
            end
            default: begin
              addr_d  = '0;
              din_d   = bus.cmd_data[DATA_W-1:0];
              state_d = WRITE;
            end
          endcase
        end
      end
      WRITE: begin
        if (fire) begin
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 2'd1;
            if (op_q == OP_HEX4) begin
              addr_d = {addr_q[ADDR_W-1:COL_BITS], addr_q[COL_BITS-1:0] + c_col_one};
              din_d  = nib_ext(hex_q[15:12]);
              hex_d  = {hex_q[11:0], 4'h0};
            end else begin
              addr_d = addr_q + c_addr_one;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      addr_q  <= '0;
      din_q   <= '0;
      hex_q   <= '0;
      cnt_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      hex_q   <= hex_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tile_ram_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_ram_writer
// Purpose  : Directed self-checking bench for tile_ram_writer with a RAM model.
// Revision : 1.0
// ============================================================================
module tb_tile_ram_writer;

  localparam int ROW_BITS = 5;
  localparam int COL_BITS = 5;
  localparam int DATA_W   = 8;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_PUT  = 2'd1;
  localparam logic [1:0] OP_HEX4 = 2'd2;
  localparam logic [1:0] OP_FILL = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tile_ram_writer_if #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .DATA_W(DATA_W)) bus ();

  tile_ram_writer #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RAM model and write log
  logic [7:0] mem      [0:1023];
  logic [9:0] log_addr [0:2047];
  logic [7:0] log_data [0:2047];
  int         wr_count  = 0;
  int         bad_allow = 0;
  logic       log_clr   = 1'b0;

  always @(posedge clk) begin
    if (log_clr) begin
      wr_count  <= 0;
      bad_allow <= 0;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_din;
      if (wr_count < 2048) begin
        log_addr[wr_count] <= bus.ram_addr;
        log_data[wr_count] <= bus.ram_din;
      end
      wr_count <= wr_count + 1;
      if (!bus.wr_allow) bad_allow <= bad_allow + 1;
    end
  end

  task automatic clear_log();
    @(negedge clk);
    log_clr = 1'b1;
    @(negedge clk);
    log_clr = 1'b0;
  endtask

  // Returns just after the accept edge
  task automatic send(input logic [1:0] op, input logic [4:0] row, input logic [4:0] col,
                      input logic [15:0] data);
    int k;
    @(negedge clk);
    bus.cmd_op    = op;
    bus.cmd_row   = row;
    bus.cmd_col   = col;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    k = 0;
    while (!bus.cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("accept", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  // Counts negedges after accept until done; optionally drives 1-on/3-off wr_allow
  task automatic wait_done(input int max, input bit gated, output int cycles, output bit busy_ok);
    cycles  = 0;
    busy_ok = 1'b1;
    while (cycles < max) begin
      @(negedge clk);
      cycles++;
      if (bus.done) break;
      if (!bus.busy) busy_ok = 1'b0;
      if (gated) bus.wr_allow = (cycles % 4 == 0);
    end
  endtask

  int hex_a [4] = '{32'h05E, 32'h05F, 32'h040, 32'h041};
  int hex_d [4] = '{32'h01, 32'h02, 32'h0E, 32'h0F};

  initial begin
    int cyc;
    bit bok;
    int bad;
    int k;
    bit done_seen;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_row   = '0;
    bus.cmd_col   = '0;
    bus.cmd_data  = 16'd0;
    bus.wr_allow  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("rst_done",  {31'd0, bus.done}, 32'd0);
    check("rst_we",    {31'd0, bus.ram_we}, 32'd0);
    check("rst_addr",  {22'd0, bus.ram_addr}, 32'd0);
    check("rst_din",   {24'd0, bus.ram_din}, 32'd0);
    reset = 1'b0;

    // PUT row 3 col 5
    clear_log();
    send(OP_PUT, 5'd3, 5'd5, 16'h00A7);
    @(negedge clk);
    check("put_we",   {31'd0, bus.ram_we}, 32'd1);
    check("put_addr", {22'd0, bus.ram_addr}, 32'h065);
    check("put_din",  {24'd0, bus.ram_din}, 32'hA7);
    check("put_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    check("put_done",  {31'd0, bus.done}, 32'd1);
    check("put_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("put_we_off", {31'd0, bus.ram_we}, 32'd0);
    @(negedge clk);
    check("put_done_pulse", {31'd0, bus.done}, 32'd0);
    check("put_count", wr_count, 32'd1);

    // HEX4 with column wrap
    clear_log();
    send(OP_HEX4, 5'd2, 5'd30, 16'h12EF);
    wait_done(20, 1'b0, cyc, bok);
    check("hex_done",   {31'd0, bus.done}, 32'd1);
    check("hex_cycles", cyc, 32'd5);
    check("hex_busy",   {31'd0, bok}, 32'd1);
    check("hex_count",  wr_count, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hex_addr%0d", i), {22'd0, log_addr[i]}, hex_a[i]);
      check($sformatf("hex_data%0d", i), {24'd0, log_data[i]}, hex_d[i]);
    end

    // HEX4 with wr_allow 1-on/3-off
    clear_log();
    bus.wr_allow = 1'b0;
    send(OP_HEX4, 5'd2, 5'd30, 16'h12EF);
    wait_done(60, 1'b1, cyc, bok);
    bus.wr_allow = 1'b1;
    check("hexg_done",   {31'd0, bus.done}, 32'd1);
    check("hexg_cycles", cyc, 32'd17);
    check("hexg_busy",   {31'd0, bok}, 32'd1);
    check("hexg_count",  wr_count, 32'd4);
    check("hexg_allow",  bad_allow, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hexg_addr%0d", i), {22'd0, log_addr[i]}, hex_a[i]);
      check($sformatf("hexg_data%0d", i), {24'd0, log_data[i]}, hex_d[i]);
    end

    // FILL whole screen (row/col ignored)
    clear_log();
    send(OP_FILL, 5'd7, 5'd9, 16'h0020);
    wait_done(1100, 1'b0, cyc, bok);
    check("fill_done",   {31'd0, bus.done}, 32'd1);
    check("fill_cycles", cyc, 32'd1025);
    check("fill_count",  wr_count, 32'd1024);
    bad = 0;
    for (int i = 0; i < 1024; i++) if ({22'd0, log_addr[i]} != i) bad++;
    check("fill_order", bad, 32'd0);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== 8'h20) bad++;
    check("fill_mem", bad, 32'd0);

    // NOP
    clear_log();
    send(OP_NOP, 5'd1, 5'd1, 16'hFFFF);
    wait_done(5, 1'b0, cyc, bok);
    check("nop_done",   {31'd0, bus.done}, 32'd1);
    check("nop_cycles", cyc, 32'd1);
    check("nop_count",  wr_count, 32'd0);

    // Command held while busy is accepted only once ready returns
    clear_log();
    bus.wr_allow = 1'b0;
    send(OP_PUT, 5'd1, 5'd1, 16'h0011);
    @(negedge clk);
    bus.cmd_op    = OP_PUT;
    bus.cmd_row   = 5'd4;
    bus.cmd_col   = 5'd4;
    bus.cmd_data  = 16'h0044;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("hold_ready%0d", i), {31'd0, bus.cmd_ready}, 32'd0);
    end
    check("hold_count", wr_count, 32'd0);
    bus.wr_allow = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.cmd_ready && k < 20);
    check("hold_ready_back", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    wait_done(10, 1'b0, cyc, bok);
    check("hold_done",  {31'd0, bus.done}, 32'd1);
    check("hold_count2", wr_count, 32'd2);
    check("hold_a0", {22'd0, log_addr[0]}, 32'h021);
    check("hold_d0", {24'd0, log_data[0]}, 32'h11);
    check("hold_a1", {22'd0, log_addr[1]}, 32'h084);
    check("hold_d1", {24'd0, log_data[1]}, 32'h44);

    // Reset during FILL after 100 writes
    clear_log();
    send(OP_FILL, 5'd0, 5'd0, 16'h0033);
    k = 0;
    while (wr_count < 100 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("abort_progress", wr_count, 32'd100);
    reset = 1'b1;
    #1;
    check("abort_we", {31'd0, bus.ram_we}, 32'd0);
    @(negedge clk);
    check("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("abort_busy",  {31'd0, bus.busy}, 32'd0);
    check("abort_done",  {31'd0, bus.done}, 32'd0);
    check("abort_addr",  {22'd0, bus.ram_addr}, 32'd0);
    check("abort_din",   {24'd0, bus.ram_din}, 32'd0);
    reset = 1'b0;
    done_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) done_seen = 1'b1;
    end
    check("abort_no_done", {31'd0, done_seen}, 32'd0);
    check("abort_count",   wr_count, 32'd100);
    check("abort_mem99",   {24'd0, mem[99]}, 32'h33);
    check("abort_mem100",  {24'd0, mem[100]}, 32'h20);

    clear_log();
    send(OP_PUT, 5'd31, 5'd31, 16'h005A);
    wait_done(10, 1'b0, cyc, bok);
    check("post_done",  {31'd0, bus.done}, 32'd1);
    check("post_count", wr_count, 32'd1);
    check("post_addr",  {22'd0, log_addr[0]}, 32'h3FF);
    check("post_mem",   {24'd0, mem[1023]}, 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
